cmpx_mul_arbiter: RTL and testbench

//  Shares one complex multiplier between NREQ twiddle-multiply requesters, e.g. the butterfly

---
 rtl/cmpx_mul_arbiter.sv | 131 +++++++++++++
 tb/tb_cmpx_mul_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmpx_mul_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between NREQ requesters.
// Two-stage stallable pipeline: S1 holds the granted operands, S2 holds the product and drives rsp_*.
module cmpx_mul_arbiter #(
  parameter int M    = 8,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*M-1:0]     req_a_re,
  input  logic [NREQ*M-1:0]     req_a_im,
  input  logic [NREQ*M-1:0]     req_b_re,
  input  logic [NREQ*M-1:0]     req_b_im,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic signed [2*M:0]   rsp_real,
  output logic signed [2*M:0]   rsp_imag
);

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Each product is a full 2M-bit signed value, sign-extended by one bit before combining.
  function automatic logic signed [2*M:0] cmul_re(input logic signed [M-1:0] ar, input logic signed [M-1:0] ai,
                                                  input logic signed [M-1:0] br, input logic signed [M-1:0] bi);
    logic signed [2*M-1:0] p1, p2;
    p1 = ar * br;
    p2 = ai * bi;
    return {p1[2*M-1], p1} - {p2[2*M-1], p2};
  endfunction

  function automatic logic signed [2*M:0] cmul_im(input logic signed [M-1:0] ar, input logic signed [M-1:0] ai,
                                                  input logic signed [M-1:0] br, input logic signed [M-1:0] bi);
    logic signed [2*M-1:0] p1, p2;
    p1 = ai * br;
    p2 = ar * bi;
    return {p1[2*M-1], p1} + {p2[2*M-1], p2};
  endfunction

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  v1_q, v2_q;
  logic [IDW-1:0]        s1_id_q, s2_id_q;
  logic signed [M-1:0]   s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q;
  logic signed [2*M:0]   s2_re_q, s2_im_q;
  logic signed [2*M:0]   prod_re, prod_im;

  logic                  adv1, adv2;
  logic                  gnt_any, grant;
  logic [IDW-1:0]        gnt_idx;

  assign adv2 = !v2_q || rsp_ready;
  assign adv1 = !v1_q || adv2;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[rr_idx(ptr_q, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(ptr_q, k);
      end
    end
  end

  assign grant = gnt_any && adv1 && !rst;

  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
      ptr_d              = rr_idx(gnt_idx, 1);
    end
  end

  assign prod_re = cmul_re(s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q);
  assign prod_im = cmul_im(s1_a_re_q, s1_a_im_q, s1_b_re_q, s1_b_im_q);

  // Stage 1: operand capture from the granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      v1_q      <= 1'b0;
      s1_id_q   <= '0;
      s1_a_re_q <= '0;
      s1_a_im_q <= '0;
      s1_b_re_q <= '0;
      s1_b_im_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant) begin
        v1_q      <= 1'b1;
        s1_id_q   <= gnt_idx;
        s1_a_re_q <= req_a_re[gnt_idx*M +: M];
        s1_a_im_q <= req_a_im[gnt_idx*M +: M];
        s1_b_re_q <= req_b_re[gnt_idx*M +: M];
        s1_b_im_q <= req_b_im[gnt_idx*M +: M];
      end else if (adv1) begin
        v1_q <= 1'b0;
      end
    end
  end

  // Stage 2: product register, drives the response port
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      s2_id_q <= '0;
      s2_re_q <= '0;
      s2_im_q <= '0;
    end else if (adv2) begin
      v2_q    <= v1_q;
      s2_id_q <= s1_id_q;
      s2_re_q <= prod_re;
      s2_im_q <= prod_im;
    end
  end

  assign rsp_valid = v2_q;
  assign rsp_id    = s2_id_q;
  assign rsp_real  = s2_re_q;
  assign rsp_imag  = s2_im_q;

endmodule

// File: tb/tb_cmpx_mul_arbiter.sv
// Self-checking bench for cmpx_mul_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against an in-order scoreboard model.
module tb_cmpx_mul_arbiter;
  localparam int M    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*M-1:0]    req_a_re, req_a_im, req_b_re, req_b_im;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic signed [2*M:0]  rsp_real, rsp_imag;

  cmpx_mul_arbiter #(.M(M), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_re(req_a_re), .req_a_im(req_a_im), .req_b_re(req_b_re), .req_b_im(req_b_im),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_real(rsp_real), .rsp_imag(rsp_imag)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int re; int im; } exp_t;
  typedef struct { int ar; int ai; int br; int bi; int er; int ei; } vec_t;

  exp_t q[$];
  int   ptr_m;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [NREQ-1:0] obs_ready;
  logic            obs_rsp_valid;
  int              obs_id, obs_re, obs_im;
  logic            hold_prev = 1'b0;
  int              hold_id, hold_re, hold_im;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int i, input int ar, input int ai, input int br, input int bi);
    req_a_re[i*M +: M] = ar[M-1:0];
    req_a_im[i*M +: M] = ai[M-1:0];
    req_b_re[i*M +: M] = br[M-1:0];
    req_b_im[i*M +: M] = bi[M-1:0];
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  // One clock: observe at the falling edge, compare against the model, advance the model.
  task automatic cycle();
    int g, idx, exp_rdy, ar, ai, br, bi;
    exp_t e;
    @(negedge clk);
    obs_ready     = req_ready;
    obs_rsp_valid = rsp_valid;
    obs_id        = int'(rsp_id);
    obs_re        = int'(rsp_real);
    obs_im        = int'(rsp_imag);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr_m + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_rdy = (!rst && g >= 0 && (q.size() < 2 || rsp_ready)) ? (1 << g) : 0;
    check("req_ready", longint'(obs_ready), exp_rdy);
    if (!rst) begin
      if (hold_prev) begin
        check("hold_valid", obs_rsp_valid, 1);
        check("hold_id", obs_id, hold_id);
        check("hold_real", obs_re, hold_re);
        check("hold_imag", obs_im, hold_im);
      end
      if (q.size() == 0) check("rsp_spurious_valid", obs_rsp_valid, 0);
      else if (obs_rsp_valid) begin
        check("rsp_id", obs_id, q[0].id);
        check("rsp_real", obs_re, q[0].re);
        check("rsp_imag", obs_im, q[0].im);
      end
    end
    hold_prev = !rst && obs_rsp_valid && !rsp_ready;
    hold_id = obs_id; hold_re = obs_re; hold_im = obs_im;
    if (rst) begin
      q.delete();
      ptr_m = 0;
    end else begin
      if (obs_rsp_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
      if (exp_rdy != 0) begin
        ar = int'($signed(req_a_re[g*M +: M]));
        ai = int'($signed(req_a_im[g*M +: M]));
        br = int'($signed(req_b_re[g*M +: M]));
        bi = int'($signed(req_b_im[g*M +: M]));
        e.id = g;
        e.re = ar * br - ai * bi;
        e.im = ai * br + ar * bi;
        q.push_back(e);
        ptr_m = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
    check("drain_empty", q.size(), 0);
  endtask

  vec_t vecs[9];
  int   ng;

  initial begin
    vecs[0] = '{3, 4, 2, -1, 10, 5};
    vecs[1] = '{-128, -128, -128, -128, 0, 32768};
    vecs[2] = '{-128, -128, -128, 127, 32640, 128};
    vecs[3] = '{127, 127, 127, 127, 0, 32258};
    vecs[4] = '{127, -128, -128, 127, 0, 32513};
    vecs[5] = '{-1, 0, 1, 0, -1, 0};
    vecs[6] = '{0, -128, 0, 127, 16256, 0};
    vecs[7] = '{5, -7, -3, 2, -1, 31};
    vecs[8] = '{-128, 127, 127, -128, 0, 32513};

    ptr_m = 0;
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a_re = '0; req_a_im = '0; req_b_re = '0; req_b_im = '0;
    cycle();
    cycle();
    check("rst_ready_zero", longint'(obs_ready), 0);
    rst = 1'b0;
    req_valid = '0;
    cycle();
    check("rst_rsp_valid", obs_rsp_valid, 0);
    check("rst_rsp_id", obs_id, 0);
    check("rst_rsp_real", obs_re, 0);
    check("rst_rsp_imag", obs_im, 0);

    // Directed vectors: single requester, exact 2-cycle latency
    for (int v = 0; v < 9; v++) begin
      int i;
      i = (v + 2) % NREQ;
      set_ops(i, vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi);
      req_valid = '0;
      req_valid[i] = 1'b1;
      cycle();
      check("vec_grant", longint'(obs_ready), 1 << i);
      req_valid = '0;
      cycle();
      check("vec_latency_early", obs_rsp_valid, 0);
      cycle();
      check("vec_rsp_valid", obs_rsp_valid, 1);
      check("vec_rsp_id", obs_id, i);
      check("vec_real", obs_re, vecs[v].er);
      check("vec_imag", obs_im, vecs[v].ei);
    end
    drain();

    // Pointer wrap and skip
    do_reset();
    req_valid = 4'b0001; cycle();
    check("rr_first", longint'(obs_ready), 1);
    req_valid = 4'b1000; cycle();
    check("rr_skip_to_3", longint'(obs_ready), 8);
    req_valid = 4'b1010; cycle();
    check("rr_wrap_to_1", longint'(obs_ready), 2);
    drain();

    // All requesters valid: strict rotation, ids follow with two-cycle lag
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      req_valid = (k < 8) ? '1 : '0;
      cycle();
      if (k < 8) check("rot_grant", longint'(obs_ready), 1 << (k % 4));
      if (k >= 2) begin
        check("rot_rsp_valid", obs_rsp_valid, 1);
        check("rot_rsp_id", obs_id, (k - 2) % 4);
      end
    end
    drain();

    // Backpressure: only two requests fit in the pipeline
    ng = 0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      req_valid = '1;
      cycle();
      if (obs_ready != 0) ng++;
    end
    check("bp_accepted", ng, 2);
    check("bp_ready_blocked", longint'(obs_ready), 0);
    drain();

    // Reset while both stages are full
    rsp_ready = 1'b0;
    req_valid = '1;
    rand_ops();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_ready_zero", longint'(obs_ready), 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    check("midrst_rsp_valid", obs_rsp_valid, 0);
    check("midrst_rsp_real", obs_re, 0);
    check("midrst_first_grant", longint'(obs_ready), 1);
    drain();

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
